// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : LC-3b instruction fetch engine. Owns the PC, issues held memory
//            reads and hands fetched words to the IR over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] mem_address,
    output logic        mem_read,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_load,
    input  logic [15:0] pc_target
);

    localparam logic [15:0] C_RESET_PC = RESET_PC & 16'hFFFE;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_pc, w_pc_next;
    logic [15:0] r_pending, w_pending_next;
    logic [15:0] r_instr, w_instr_next;
    logic [15:0] r_instr_pc, w_instr_pc_next;
    logic [15:0] w_target;
    logic        w_unused_bit;

    assign w_target     = {pc_target[15:1], 1'b0};
    assign w_unused_bit = pc_target[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_pc       <= C_RESET_PC;
            r_pending  <= 16'h0000;
            r_instr    <= 16'h0000;
            r_instr_pc <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pending  <= w_pending_next;
            r_instr    <= w_instr_next;
            r_instr_pc <= w_instr_pc_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_pending_next  = r_pending;
        w_instr_next    = r_instr;
        w_instr_pc_next = r_instr_pc;
        case (r_state)
            S_FETCH: begin
                if (mem_resp && pc_load) begin
                    // Data from the old stream is dropped; refetch at target.
                    w_pc_next = w_target;
                end else if (mem_resp) begin
                    w_instr_next    = mem_rdata;
                    w_instr_pc_next = r_pc;
                    w_pc_next       = r_pc + PC_STEP;
                    w_state_next    = S_HOLD;
                end else if (pc_load) begin
                    // Read cannot be aborted; wait for it and discard its data.
                    w_pending_next = w_target;
                    w_state_next   = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (pc_load) begin
                    w_pending_next = w_target;
                end
                if (mem_resp) begin
                    w_pc_next    = pc_load ? w_target : r_pending;
                    w_state_next = S_FETCH;
                end
            end
            S_HOLD: begin
                if (pc_load) begin
                    w_pc_next    = w_target;
                    w_state_next = S_FETCH;
                end else if (instr_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    assign mem_read    = (r_state == S_FETCH) || (r_state == S_FLUSH);
    assign mem_address = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Directed and randomized bench for ifetch_unit against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [15:0] RESET_PC = 16'h3001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_load;
    logic [15:0] pc_target;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: a read is either wanted (useful), stale (to be discarded), or
    // the fetched word is parked waiting for the consumer.
    bit          m_reading;
    bit          m_stale;
    bit          m_parked;
    logic [15:0] m_pc;
    logic [15:0] m_redirect;
    logic [15:0] m_word;
    logic [15:0] m_word_pc;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (16'd2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_load     (pc_load),
        .pc_target   (pc_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rn, input bit pl, input logic [15:0] tgt,
                              input bit resp, input logic [15:0] rd, input bit rdy);
        logic [15:0] t;
        t = tgt & 16'hFFFE;
        if (!rn) begin
            m_pc = RESET_PC & 16'hFFFE;
            m_reading = 1; m_stale = 0; m_parked = 0;
            m_word = 0; m_word_pc = 0; m_redirect = 0;
        end else if (m_parked) begin
            if (pl) m_pc = t;
            if (pl || rdy) begin
                m_parked = 0; m_reading = 1;
            end
        end else if (!m_stale) begin
            if (resp && pl) begin
                m_pc = t;
            end else if (resp) begin
                m_word = rd; m_word_pc = m_pc; m_pc = m_pc + 16'd2;
                m_parked = 1; m_reading = 0;
            end else if (pl) begin
                m_redirect = t; m_stale = 1;
            end
        end else begin
            if (pl) m_redirect = t;
            if (resp) begin
                m_pc = pl ? t : m_redirect;
                m_stale = 0;
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit pl, input logic [15:0] tgt,
                       input bit resp, input logic [15:0] rd, input bit rdy);
        @(negedge clk);
        if (chk_en) begin
            check("mem_read",    {15'd0, mem_read},    {15'd0, m_reading});
            check("mem_address", mem_address,          m_pc);
            check("instr_valid", {15'd0, instr_valid}, {15'd0, m_parked});
            check("instr",       instr,                m_word);
            check("instr_pc",    instr_pc,             m_word_pc);
        end
        reset_n = rn; pc_load = pl; pc_target = tgt;
        mem_resp = resp; mem_rdata = rd; instr_ready = rdy;
        @(posedge clk);
        model_edge(rn, pl, tgt, resp, rd, rdy);
    endtask

    initial begin
        reset_n = 0; pc_load = 0; pc_target = 0;
        mem_resp = 0; mem_rdata = 0; instr_ready = 0;
        m_reading = 0; m_stale = 0; m_parked = 0;
        m_pc = 0; m_redirect = 0; m_word = 0; m_word_pc = 0;

        // Reset with an odd RESET_PC.
        cyc(0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_addr", mem_address, 16'h3000);

        // Move to PC 0 with a same-cycle redirect/response.
        cyc(1, 1, 16'h0000, 1, 16'h7777, 0);

        // Two wait cycles, then 16'h1261, then backpressure for 5 cycles.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 16'h1261, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 16'hDEAD, 0);
        check("bp_instr", instr, 16'h1261);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        check("next_addr", mem_address, 16'h0002);

        // Fetch at 0002, then redirect in HOLD together with instr_ready.
        cyc(1, 0, 0, 1, 16'h5A5A, 0);
        cyc(1, 1, 16'h4005, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        check("hold_redirect", mem_address, 16'h4004);

        // Two redirects during an outstanding read; BEEF must be dropped.
        cyc(1, 1, 16'h0100, 0, 0, 1);
        cyc(1, 1, 16'h0200, 0, 0, 1);
        cyc(1, 0, 0, 1, 16'hBEEF, 1);
        cyc(1, 0, 0, 0, 0, 1);
        check("flush_addr", mem_address, 16'h0200);

        // Same-cycle redirect and response in FETCH.
        cyc(1, 1, 16'h0040, 1, 16'hCAFE, 1);
        cyc(1, 0, 0, 0, 0, 1);
        check("same_cycle_addr", mem_address, 16'h0040);

        // PC wrap from FFFE.
        cyc(1, 1, 16'hFFFF, 1, 0, 1);
        cyc(1, 0, 0, 1, 16'h0F0F, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        check("wrap_addr", mem_address, 16'h0000);

        // Reset while holding an instruction.
        cyc(1, 0, 0, 1, 16'hA5A5, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_hold_addr", mem_address, 16'h3000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 5) == 0),
                16'($urandom),
                ($urandom_range(0, 2) == 0),
                16'($urandom),
                ($urandom_range(0, 1) == 1));
        end
        cyc(1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
